pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-register PC.
- Adds configurable width, reset vector and step, plus an opcode-driven next-PC mux: hold, increment, absolute load, relative branch, call and return.
- Integrated return-address stack (RAS) for call/return.
- Sits between control unit and memory address path.
- Single clock domain; all PC updates happen on the clk edge. No separate increment strobe.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_ras.sv | 52 +++++
 rtl/pc_unit.sv | 102 ++++++++++
 tb/tb_pc_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: opcode encoding and pointer sizing.
package pc_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } pc_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata_c,
  output logic         full_c,
  output logic         empty_c,
  output logic         ovf_c,
  output logic         unf_c
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     mem [DEPTH];

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign ovf_c   = push & full_c;
  assign unf_c   = pop & empty_c;
  assign rdata_c = mem[sp - PTR_W'(1)];

  // Pointer and occupancy; a pop on an empty stack leaves both untouched
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PTR_W'(1);
      if (!full_c) count <= count + CNT_W'(1);
    end else if (pop && !empty_c) begin
      sp    <= sp - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; it is never observed while empty
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with opcode-driven next-PC mux and integrated return-address stack.
// Optional macro PC_PREV_EN adds prev_q, the value q held before its latest change.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned    W         = 32,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter logic [W-1:0]   STEP      = W'(1),
  parameter int unsigned    DEPTH     = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    d,
  input  logic            clr_err,
  output logic [W-1:0]    q,
  output logic            stk_full,
  output logic            stk_empty,
`ifdef PC_PREV_EN
  output logic [W-1:0]    prev_q,
`endif
  output logic            stk_err
);

  logic [W-1:0] q_nxt;
  logic         err_nxt;
  logic         ras_push;
  logic         ras_pop;
  logic [W-1:0] ras_rdata;
  logic [W-1:0] ret_addr;
  logic         ras_ovf;
  logic         ras_unf;
  pc_op_e       op_e;

  assign op_e     = pc_op_e'(op);
  assign ret_addr = q + STEP;

  pc_ras #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk     (clk),
    .clr     (clr),
    .push    (ras_push),
    .pop     (ras_pop),
    .wdata   (ret_addr),
    .rdata_c (ras_rdata),
    .full_c  (stk_full),
    .empty_c (stk_empty),
    .ovf_c   (ras_ovf),
    .unf_c   (ras_unf)
  );

  // Next-PC mux and stack requests; everything holds while en is low
  always_comb begin
    q_nxt    = q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (en) begin
      case (op_e)
        OP_INC:    q_nxt = ret_addr;
        OP_LOAD:   q_nxt = d;
        OP_BRANCH: q_nxt = ret_addr + d;
        OP_CALL: begin
          ras_push = 1'b1;
          q_nxt    = d;
        end
        OP_RET: begin
          ras_pop = 1'b1;
          if (!stk_empty) q_nxt = ras_rdata;
        end
        default:   q_nxt = q;
      endcase
    end
  end

  // A new error takes priority over a same-cycle clear
  always_comb begin
    err_nxt = stk_err;
    if (clr_err)           err_nxt = 1'b0;
    if (ras_ovf | ras_unf) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q       <= RESET_VEC;
      stk_err <= 1'b0;
    end else begin
      q       <= q_nxt;
      stk_err <= err_nxt;
    end
  end

`ifdef PC_PREV_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)               prev_q <= RESET_VEC;
    else if (q_nxt != q)    prev_q <= q;
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RESET_VEC=0x100, STEP=1, DEPTH=4).
module tb_pc_unit;

  logic        clk;
  logic        clr;
  logic        en;
  logic [2:0]  op;
  logic [31:0] d;
  logic        clr_err;
  logic [31:0] q;
  logic        stk_full;
  logic        stk_empty;
  logic        stk_err;
`ifdef PC_PREV_EN
  logic [31:0] prev_q;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7;

  pc_unit #(
    .W         (32),
    .RESET_VEC (32'h100),
    .STEP      (32'd1),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .op        (op),
    .d         (d),
    .clr_err   (clr_err),
    .q         (q),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
`ifdef PC_PREV_EN
    .prev_q    (prev_q),
`endif
    .stk_err   (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [2:0] o, input logic [31:0] dd, input logic ce);
    en = e; op = o; d = dd; clr_err = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b0; en = 1'b0; op = HOLD; d = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (q !== 32'h100) begin bad++; $display("FAIL reset_q got=%h want=%h", q, 32'h100); end
    total++; if (stk_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", stk_empty); end
    total++; if (stk_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", stk_full); end
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", stk_err); end
`ifdef PC_PREV_EN
    total++; if (prev_q !== 32'h100) begin bad++; $display("FAIL reset_prev got=%h want=%h", prev_q, 32'h100); end
`endif
    clr = 1'b1;
  endtask

  task automatic test_inc;
    logic [31:0] exp_q [3];
    exp_q[0] = 32'h101; exp_q[1] = 32'h102; exp_q[2] = 32'h103;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, INC, 32'h0, 1'b0);
      total++; if (q !== exp_q[i]) begin bad++; $display("FAIL inc_%0d got=%h want=%h", i, q, exp_q[i]); end
    end
`ifdef PC_PREV_EN
    total++; if (prev_q !== 32'h102) begin bad++; $display("FAIL inc_prev got=%h want=%h", prev_q, 32'h102); end
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b0, INC, 32'h0, 1'b0);
      total++; if (q !== 32'h103) begin bad++; $display("FAIL stall_%0d got=%h want=%h", i, q, 32'h103); end
    end
`ifdef PC_PREV_EN
    total++; if (prev_q !== 32'h102) begin bad++; $display("FAIL stall_prev got=%h want=%h", prev_q, 32'h102); end
`endif
  endtask

  task automatic test_branch;
    step(1'b1, LOAD, 32'h200, 1'b0);
    total++; if (q !== 32'h200) begin bad++; $display("FAIL load got=%h want=%h", q, 32'h200); end
    step(1'b1, BRANCH, 32'hFFFF_FFF0, 1'b0);
    total++; if (q !== 32'h1F1) begin bad++; $display("FAIL branch_back got=%h want=%h", q, 32'h1F1); end
    step(1'b1, BRANCH, 32'h0000_0010, 1'b0);
    total++; if (q !== 32'h202) begin bad++; $display("FAIL branch_fwd got=%h want=%h", q, 32'h202); end
    step(1'b1, RSV6, 32'h55, 1'b0);
    step(1'b1, RSV7, 32'h55, 1'b0);
    step(1'b1, HOLD, 32'h55, 1'b0);
    total++; if (q !== 32'h202) begin bad++; $display("FAIL reserved_q got=%h want=%h", q, 32'h202); end
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL reserved_err got=%b want=0", stk_err); end
    step(1'b1, LOAD, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, INC, 32'h0, 1'b0);
    total++; if (q !== 32'h0) begin bad++; $display("FAIL wrap_q got=%h want=0", q); end
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b want=0", stk_err); end
  endtask

  task automatic test_call_ret;
    step(1'b1, LOAD, 32'h10, 1'b0);
    step(1'b1, CALL, 32'h40, 1'b0);
    total++; if (q !== 32'h40) begin bad++; $display("FAIL call1 got=%h want=%h", q, 32'h40); end
    step(1'b1, CALL, 32'h80, 1'b0);
    total++; if (q !== 32'h80) begin bad++; $display("FAIL call2 got=%h want=%h", q, 32'h80); end
    total++; if ({stk_full, stk_empty} !== 2'b00) begin bad++; $display("FAIL call2_flags got=%b want=00", {stk_full, stk_empty}); end
    step(1'b0, RET, 32'h0, 1'b0);
    total++; if (q !== 32'h80) begin bad++; $display("FAIL ret_stall got=%h want=%h", q, 32'h80); end
    step(1'b1, RET, 32'h0, 1'b0);
    total++; if (q !== 32'h41) begin bad++; $display("FAIL ret1 got=%h want=%h", q, 32'h41); end
    step(1'b1, RET, 32'h0, 1'b0);
    total++; if (q !== 32'h11) begin bad++; $display("FAIL ret2 got=%h want=%h", q, 32'h11); end
    total++; if (stk_empty !== 1'b1) begin bad++; $display("FAIL ret2_empty got=%b want=1", stk_empty); end
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL ret2_err got=%b want=0", stk_err); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h5; exp_ret[1] = 32'h4; exp_ret[2] = 32'h3; exp_ret[3] = 32'h2;
    step(1'b1, LOAD, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, CALL, 32'(i), 1'b0);
    total++; if ({stk_full, stk_err} !== 2'b10) begin bad++; $display("FAIL full4 full_err got=%b want=10", {stk_full, stk_err}); end
    step(1'b1, CALL, 32'h5, 1'b0);
    total++; if (q !== 32'h5) begin bad++; $display("FAIL ovf_q got=%h want=5", q); end
    total++; if ({stk_full, stk_err} !== 2'b11) begin bad++; $display("FAIL ovf full_err got=%b want=11", {stk_full, stk_err}); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RET, 32'h0, 1'b0);
      total++; if (q !== exp_ret[i]) begin bad++; $display("FAIL ovf_ret%0d got=%h want=%h", i, q, exp_ret[i]); end
    end
    total++; if ({stk_empty, stk_err} !== 2'b11) begin bad++; $display("FAIL ovf_end empty_err got=%b want=11", {stk_empty, stk_err}); end
  endtask

  task automatic test_underflow;
    step(1'b1, LOAD, 32'h30, 1'b1);
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", stk_err); end
    step(1'b1, RET, 32'h0, 1'b0);
    total++; if (q !== 32'h30) begin bad++; $display("FAIL unf_q got=%h want=%h", q, 32'h30); end
    total++; if (stk_err !== 1'b1) begin bad++; $display("FAIL unf_err got=%b want=1", stk_err); end
    step(1'b1, HOLD, 32'h0, 1'b0);
    total++; if (stk_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", stk_err); end
    step(1'b1, HOLD, 32'h0, 1'b1);
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", stk_err); end
    step(1'b1, RET, 32'h0, 1'b1);
    total++; if (stk_err !== 1'b1) begin bad++; $display("FAIL err_priority got=%b want=1", stk_err); end
    step(1'b0, RET, 32'h0, 1'b1);
    total++; if (stk_err !== 1'b0) begin bad++; $display("FAIL clr_err_stalled got=%b want=0", stk_err); end
  endtask

  task automatic test_async_reset;
    step(1'b1, RET, 32'h0, 1'b0);
    step(1'b1, LOAD, 32'h0, 1'b0);
    step(1'b1, CALL, 32'h40, 1'b0);
    step(1'b1, CALL, 32'h80, 1'b0);
    total++; if ({q == 32'h80, stk_err} !== 2'b11) begin bad++; $display("FAIL pre_reset q80_err got=%b want=11", {q == 32'h80, stk_err}); end
    en = 1'b1; op = CALL; d = 32'h99; clr_err = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    total++; if (q !== 32'h100) begin bad++; $display("FAIL arst_q got=%h want=%h", q, 32'h100); end
    total++; if ({stk_empty, stk_full, stk_err} !== 3'b100) begin bad++; $display("FAIL arst_flags got=%b want=100", {stk_empty, stk_full, stk_err}); end
    @(posedge clk);
    #1;
    total++; if (q !== 32'h100) begin bad++; $display("FAIL arst_held got=%h want=%h", q, 32'h100); end
    clr = 1'b1;
    step(1'b1, INC, 32'h0, 1'b0);
    total++; if (q !== 32'h101) begin bad++; $display("FAIL post_reset got=%h want=%h", q, 32'h101); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
